mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle CPU between two requesters: the CPU memory interface (IorD path) and the program loader (boot/debug write port).
- Sequences each access through an issue/wait/response FSM, hides the synchronous-RAM read latency and stalls the CPU controller while it does not own the memory.
- Sits between the CPU datapath, the loader and the memory macro.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LAT, 1, memory read latency in cycles (legal range 1..7); mem_rdata is valid MEM_LAT cycles after the issue cycle

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU access request; held with cpu_we/addr/wdata stable until cpu_done
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_done  out  1  one-cycle pulse when the CPU transaction completes
cpu_rdata  out  DATA_W  read data, valid while cpu_done is high for a read
cpu_stall  out  1  cpu_req & ~cpu_done (combinational); holds the CPU FSM
ldr_req  in  1  loader request; same hold rule as cpu_req
ldr_we  in  1  1 = write, 0 = read
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_lock  in  1  loader exclusive mode; the CPU is never granted while high
ldr_done  out  1  one-cycle completion pulse for the loader
ldr_rdata  out  DATA_W  read data, valid while ldr_done is high for a read
mem_en  out  1  memory access strobe (ISSUE state only)
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, high): state=IDLE, owner=CPU, last_owner=LDR, cnt=0, rdata regs=0.
  - Reset values: all done pulses 0, mem_en/mem_we 0, mem_addr/mem_wdata 0.
  - Reset mid-transaction discards the in-flight read; no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitrate: ldr_lock=1 grants LDR only.
  - Otherwise a single requester wins.
  - If both request, the winner is the one that is not last_owner (round-robin; CPU wins the first tie after reset).
  - On a grant: register owner, set last_owner=owner, go to ISSUE. No request: stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we/addr/wdata are muxed from owner's inputs.
  - Write: owner's done pulses this cycle, then go to IDLE.
  - Read: cnt=MEM_LAT-1, then go to WAIT.
- WAIT:
  - When cnt==0, capture mem_rdata into owner's rdata register and go to RESP; else decrement cnt.
  - MEM_LAT=1 spends exactly one cycle in WAIT.
- RESP (1 cycle): owner's done=1 with registered rdata, then go to IDLE.
- Latency (req seen in IDLE at cycle 0):
  - Write done at cycle 1.
  - Read done at cycle MEM_LAT+2.
  - Minimum gap between transactions is 1 IDLE cycle.
- Requester protocol:
  - req may stay high after done; it is then a new transaction sampled in the next IDLE.
  - Changing inputs before done is illegal; behaviour is undefined, but the FSM must not hang.
- ldr_lock rising during a CPU transaction: that transaction completes normally; no further CPU grants until ldr_lock falls.
- Non-owner done is always 0; rdata registers hold their last value.
- The mem_* outputs are 0 outside ISSUE.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
  - owner encoding (OWN_CPU=0, OWN_LDR=1)
  - MEM_LAT range check constant
- Sub-module arb_rr2: combinational 2-way round-robin chooser with lock input. Ports: req_cpu, req_ldr, lock, last_owner -> grant_valid, grant_owner.

Test Plan:
- CPU read only, MEM_LAT=1, addr 0x10, mem returns 0xDEADBEEF -> mem_en at cycle 1 with addr 0x10; cpu_done and cpu_rdata=0xDEADBEEF at cycle 3; cpu_stall high cycles 0-2.
- CPU write addr 0x20, data 0x1234 -> mem_en=mem_we=1 at cycle 1; cpu_done at cycle 1; busy low at cycle 2.
- Both requesting reads, continuously -> grants alternate CPU, LDR, CPU, LDR; each done exactly once per grant; no starvation over 8 transactions.
- ldr_lock=1 with both requesting -> only LDR granted for 5 writes; cpu_stall stays 1. Drop ldr_lock -> next grant goes to CPU.
- MEM_LAT=3 read -> 3 WAIT cycles; done at cycle 5; rdata is the value present on mem_rdata at cycle 4 (not cycle 3 or 5).
- rst asserted in WAIT -> next cycle IDLE, no done pulse, all outputs 0; a new CPU read then completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_e : issue/wait/response FSM encoding
//   arb_owner_e : which requester currently owns the memory
//   CNT_W       : width of the read-latency down-counter
//   mem_lat_ok  : legality check for the MEM_LAT parameter
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LDR = 1'b1
    } arb_owner_e;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;
    // Enough bits to hold MEM_LAT_MAX-1.
    localparam int CNT_W       = 3;

    function automatic logic mem_lat_ok(input int lat);
        return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
// Combinational two-way round-robin chooser between the CPU and the loader.
// Ports:
//   req_cpu     in  CPU is requesting
//   req_ldr     in  loader is requesting
//   lock        in  loader exclusive mode: only the loader may be granted
//   last_owner  in  owner of the previous grant (loses the next tie)
//   grant_valid out a requester is granted this cycle
//   grant_owner out which requester is granted
// ---------------------------------------------------------------------------
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       req_cpu,
    input  logic       req_ldr,
    input  logic       lock,
    input  arb_owner_e last_owner,
    output logic       grant_valid,
    output arb_owner_e grant_owner
);

    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OWN_CPU;
        if (lock) begin
            // CPU requests are ignored entirely while the loader holds the lock.
            grant_valid = req_ldr;
            grant_owner = OWN_LDR;
        end else if (req_cpu && req_ldr) begin
            grant_valid = 1'b1;
            grant_owner = (last_owner == OWN_CPU) ? OWN_LDR : OWN_CPU;
        end else if (req_cpu) begin
            grant_valid = 1'b1;
            grant_owner = OWN_CPU;
        end else if (req_ldr) begin
            grant_valid = 1'b1;
            grant_owner = OWN_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single unified memory between the CPU memory interface and the
// program loader. Each access runs IDLE -> ISSUE (-> WAIT -> RESP for reads)
// and the CPU is stalled while its request is outstanding.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request (held until cpu_done)
//   cpu_done, cpu_rdata      CPU completion pulse and read data
//   cpu_stall                cpu_req & ~cpu_done
//   ldr_req/we/addr/wdata    loader request (held until ldr_done)
//   ldr_lock                 loader exclusive mode
//   ldr_done, ldr_rdata      loader completion pulse and read data
//   mem_en/we/addr/wdata     memory strobe and request, nonzero only in ISSUE
//   mem_rdata                memory read data, valid MEM_LAT cycles after ISSUE
//   busy                     FSM is not idle
// Latency from the IDLE cycle that sees the request: write done +1,
// read done +MEM_LAT+2.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_done,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    generate
        if (!mem_lat_ok(MEM_LAT)) begin : g_bad_lat
            $error("mem_port_arbiter: MEM_LAT must be within 1..7");
        end
    endgenerate

    // Reload value for the WAIT down-counter; WAIT lasts MEM_LAT cycles.
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    arb_state_e        r_state, w_state_nxt;
    arb_owner_e        r_owner, w_owner_nxt;
    arb_owner_e        r_last_owner, w_last_owner_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;
    logic              w_cap_cpu;
    logic              w_cap_ldr;

    logic              w_grant_valid;
    arb_owner_e        w_grant_owner;

    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    arb_rr2 u_arb (
        .req_cpu     (cpu_req),
        .req_ldr     (ldr_req),
        .lock        (ldr_lock),
        .last_owner  (r_last_owner),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    // Requesters hold their inputs until done, so the live inputs of the
    // owner can drive the memory directly without a request register.
    always_comb begin
        if (r_owner == OWN_LDR) begin
            w_sel_we    = ldr_we;
            w_sel_addr  = ldr_addr;
            w_sel_wdata = ldr_wdata;
        end else begin
            w_sel_we    = cpu_we;
            w_sel_addr  = cpu_addr;
            w_sel_wdata = cpu_wdata;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_cnt_nxt        = r_cnt;
        w_cap_cpu        = 1'b0;
        w_cap_ldr        = 1'b0;
        mem_en           = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        cpu_done         = 1'b0;
        ldr_done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_owner_nxt      = w_grant_owner;
                    w_last_owner_nxt = w_grant_owner;
                    w_state_nxt      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = w_sel_we;
                mem_addr  = w_sel_addr;
                mem_wdata = w_sel_wdata;
                if (w_sel_we) begin
                    // Writes complete in the issue cycle itself.
                    cpu_done    = (r_owner == OWN_CPU);
                    ldr_done    = (r_owner == OWN_LDR);
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_cap_cpu   = (r_owner == OWN_CPU);
                    w_cap_ldr   = (r_owner == OWN_LDR);
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                cpu_done    = (r_owner == OWN_CPU);
                ldr_done    = (r_owner == OWN_LDR);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_CPU;
            r_last_owner <= OWN_LDR;
            r_cnt        <= '0;
            r_cpu_rdata  <= '0;
            r_ldr_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_cnt        <= w_cnt_nxt;
            if (w_cap_cpu) begin
                r_cpu_rdata <= mem_rdata;
            end
            if (w_cap_ldr) begin
                r_ldr_rdata <= mem_rdata;
            end
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign ldr_rdata = r_ldr_rdata;
    assign cpu_stall = cpu_req & ~cpu_done;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
    } exp_t;

    logic clk, rst, mem_clr;

    // DUT with MEM_LAT=1
    logic        cpu_req, cpu_we, cpu_done, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        ldr_req, ldr_we, ldr_lock, ldr_done;
    logic [31:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // DUT with MEM_LAT=3
    logic        c3_req, c3_we, c3_done, c3_stall;
    logic [31:0] c3_addr, c3_wdata, c3_rdata;
    logic        l3_req, l3_we, l3_lock, l3_done;
    logic [31:0] l3_addr, l3_wdata, l3_rdata;
    logic        m3_en, m3_we, b3;
    logic [31:0] m3_addr, m3_wdata, m3_rdata;

    int n_checks = 0;
    int n_errors = 0;

    exp_t cpu_q[$];
    exp_t ldr_q[$];
    exp_t q3[$];
    logic grant_log[$];
    exp_t mon_e, mon_l, mon_3;

    logic [31:0] cyc;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_done(c3_done), .cpu_rdata(c3_rdata), .cpu_stall(c3_stall),
        .ldr_req(l3_req), .ldr_we(l3_we), .ldr_addr(l3_addr), .ldr_wdata(l3_wdata),
        .ldr_lock(l3_lock), .ldr_done(l3_done), .ldr_rdata(l3_rdata),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
        .mem_rdata(m3_rdata), .busy(b3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst) cyc <= 32'd0;
        else     cyc <= cyc + 32'd1;
    end

    // Memory model for the MEM_LAT=1 DUT: one-cycle synchronous read.
    // Contents: word i holds A5A5_00ii, except 0x10 which holds DEADBEEF.
    logic [31:0] mem_arr [0:255];
    logic [31:0] mem_rd;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++)
                mem_arr[i] <= (i == 16) ? 32'hDEADBEEF : (32'hA5A5_0000 | 32'(i));
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr[7:0]] <= mem_wdata;
            else        mem_rd <= mem_arr[mem_addr[7:0]];
        end
    end
    assign mem_rdata = mem_rd;

    // The MEM_LAT=3 DUT sees a value that changes every cycle.
    assign m3_rdata = 32'hC0DE_0000 + cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: pop and compare whenever a done pulse appears.
    always @(negedge clk) begin
        if (cpu_done && ldr_done) begin
            n_checks++; n_errors++;
            $display("FAIL both_done: cpu_done=1 and ldr_done=1 in the same cycle");
        end
        if (cpu_done) begin
            grant_log.push_back(1'b0);
            if (cpu_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL cpu_done_unexpected: cpu_done=1 with nothing outstanding (t=%0t)", $time);
            end else begin
                mon_e = cpu_q.pop_front();
                if (mon_e.is_rd) chk("cpu_rdata", cpu_rdata, mon_e.data);
            end
        end
        if (ldr_done) begin
            grant_log.push_back(1'b1);
            if (ldr_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL ldr_done_unexpected: ldr_done=1 with nothing outstanding (t=%0t)", $time);
            end else begin
                mon_l = ldr_q.pop_front();
                if (mon_l.is_rd) chk("ldr_rdata", ldr_rdata, mon_l.data);
            end
        end
        if (c3_done) begin
            if (q3.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL lat3_done_unexpected: cpu_done=1 with nothing outstanding");
            end else begin
                mon_3 = q3.pop_front();
                if (mon_3.is_rd) chk("lat3_sb_rdata", c3_rdata, mon_3.data);
            end
        end
        if (l3_done) begin
            n_checks++; n_errors++;
            $display("FAIL lat3_ldr_done: ldr_done=1 but loader never requested");
        end
    end

    task automatic cpu_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] ex);
        int t;
        cpu_q.push_back('{is_rd: !we, data: ex});
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        t = 0;
        do begin @(negedge clk); t++; end while (!cpu_done && t < 64);
        if (!cpu_done) begin
            n_checks++; n_errors++;
            $display("FAIL cpu_timeout: addr %0h got no cpu_done, required within 64 cycles", a);
        end
        step();
    endtask

    task automatic ldr_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] ex);
        int t;
        ldr_q.push_back('{is_rd: !we, data: ex});
        ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = wd;
        t = 0;
        do begin @(negedge clk); t++; end while (!ldr_done && t < 64);
        if (!ldr_done) begin
            n_checks++; n_errors++;
            $display("FAIL ldr_timeout: addr %0h got no ldr_done, required within 64 cycles", a);
        end
        step();
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_busy"},      busy,      1'b0);
        chk({tag, "_cpu_done"},  cpu_done,  1'b0);
        chk({tag, "_ldr_done"},  ldr_done,  1'b0);
        chk({tag, "_mem_en"},    mem_en,    1'b0);
        chk({tag, "_mem_we"},    mem_we,    1'b0);
        chk({tag, "_mem_addr"},  mem_addr,  32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
        chk({tag, "_ldr_rdata"}, ldr_rdata, 32'h0);
        chk({tag, "_cpu_stall"}, cpu_stall, 1'b0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c0;
        logic        exp_lock [7];

        rst = 1'b1; mem_clr = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
        c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0;
        l3_req = 0; l3_we = 0; l3_addr = 0; l3_wdata = 0; l3_lock = 0;
        repeat (3) step();
        rst = 1'b0; mem_clr = 1'b0;
        check_idle_outputs("reset");

        // CPU read of 0x10, MEM_LAT=1: done at cycle 3
        cpu_q.push_back('{is_rd: 1'b1, data: 32'hDEADBEEF});
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rd_stall",  cpu_stall, (k < 3));
            chk("rd_done",   cpu_done,  (k == 3));
            chk("rd_mem_en", mem_en,    (k == 1));
            if (k == 1) chk("rd_mem_addr", mem_addr, 32'h10);
            if (k == 3) chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
            step();
        end

        // CPU write 0x1234 to 0x20: done at cycle 1, idle at cycle 2
        cpu_q.push_back('{is_rd: 1'b0, data: 32'h0});
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wr_done",   cpu_done, (k == 1));
            chk("wr_mem_en", mem_en,   (k == 1));
            chk("wr_mem_we", mem_we,   (k == 1));
            chk("wr_busy",   busy,     (k == 1));
            if (k == 1) begin
                chk("wr_mem_addr",  mem_addr,  32'h20);
                chk("wr_mem_wdata", mem_wdata, 32'h1234);
            end
            step();
            if (k == 1) cpu_req = 1'b0;
        end

        // Fresh reset so the first tie goes to the CPU
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check_idle_outputs("reset2");

        // Both requesting reads continuously: C,L,C,L,...
        grant_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++)
                    cpu_txn(1'b0, 32'h30 + 32'(i), 32'h0, 32'hA5A5_0030 + 32'(i));
                cpu_req = 1'b0;
            end
            begin
                for (int j = 0; j < 4; j++)
                    ldr_txn(1'b0, 32'h40 + 32'(j), 32'h0, 32'hA5A5_0040 + 32'(j));
                ldr_req = 1'b0;
            end
        join
        chk("alt_count", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size() && i < 8; i++)
            chk("alt_owner", grant_log[i], i % 2);

        // ldr_lock: five loader writes while the CPU waits, then CPU first after unlock
        grant_log.delete();
        ldr_lock = 1'b1;
        fork
            begin
                cpu_txn(1'b0, 32'h50, 32'h0, 32'hA5A5_0050);
                cpu_req = 1'b0;
            end
            begin
                for (int j = 0; j < 5; j++) begin
                    ldr_txn(1'b1, 32'h60 + 32'(j), 32'h600 + 32'(j), 32'h0);
                    chk("lock_stall", cpu_stall, 1'b1);
                end
                ldr_lock = 1'b0;
                ldr_txn(1'b0, 32'h60, 32'h0, 32'h600);
                ldr_req = 1'b0;
            end
        join
        exp_lock = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        chk("lock_count", grant_log.size(), 7);
        for (int i = 0; i < grant_log.size() && i < 7; i++)
            chk("lock_owner", grant_log[i], exp_lock[i]);

        // MEM_LAT=3 read: done at cycle 5 with the mem_rdata of cycle 4
        c0 = cyc;
        q3.push_back('{is_rd: 1'b1, data: 32'hC0DE_0000 + c0 + 32'd4});
        c3_req = 1'b1; c3_we = 1'b0; c3_addr = 32'h70;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("lat3_done",   c3_done, (k == 5));
            chk("lat3_mem_en", m3_en,   (k == 1));
            chk("lat3_busy",   b3,      (k >= 1));
            if (k == 1) chk("lat3_mem_addr", m3_addr, 32'h70);
            if (k == 5) chk("lat3_rdata", c3_rdata, 32'hC0DE_0000 + c0 + 32'd4);
            step();
        end
        c3_req = 1'b0;

        // Reset while in WAIT: read is discarded, then a new read completes
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        step();
        step();
        @(negedge clk);
        chk("rstwait_in_wait", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0; cpu_req = 1'b0;
        check_idle_outputs("rstwait");
        repeat (3) step();
        cpu_txn(1'b0, 32'h20, 32'h0, 32'h1234);
        cpu_req = 1'b0;

        repeat (4) step();
        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("ldr_q_empty", ldr_q.size(), 0);
        chk("q3_empty",    q3.size(),    0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
